// File: rtl/reg_wb_queue_pkg.sv
// Shared types and helpers for the register-file write-back queue.
// Default widths, the per-entry flag struct and the pointer-width helper live here.
package reg_wb_queue_pkg;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;

  localparam logic [DefDataW-1:0] ZERO_WORD = '0;

  // Per-entry status; addr/data are stored alongside in width-parameterised arrays.
  typedef struct packed {
    logic valid;
    logic killed;
  } wbq_flags_t;

  function automatic int unsigned ptr_w(input int unsigned depth);
    return ($clog2(depth) > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/wbq_fifo.sv
// Circular buffer for extended-unit writes with per-entry WAW kill marking.
// Exposes every entry plus the read pointer so the parent can search youngest-first.
module wbq_fifo
  import reg_wb_queue_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PtrW  = ptr_w(DEPTH),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  logic                          push_kill_i,
  input  logic [ADDR_W-1:0]             push_addr_i,
  input  logic [DATA_W-1:0]             push_data_i,
  input  logic                          pop_i,
  input  logic                          kill_i,
  input  logic [ADDR_W-1:0]             kill_addr_i,
  output logic [CntW-1:0]               count_o,
  output logic [PtrW-1:0]               rd_ptr_o,
  output logic [DEPTH-1:0]              ent_valid_o,
  output logic [DEPTH-1:0]              ent_killed_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]  ent_addr_o,
  output logic [DEPTH-1:0][DATA_W-1:0]  ent_data_o
);

  wbq_flags_t [DEPTH-1:0]             flags_q, flags_d;
  logic       [DEPTH-1:0][ADDR_W-1:0] addr_q, addr_d;
  logic       [DEPTH-1:0][DATA_W-1:0] data_q, data_d;
  logic       [PtrW-1:0]              rd_ptr_q, rd_ptr_d;
  logic       [PtrW-1:0]              wr_ptr_q, wr_ptr_d;
  logic       [CntW-1:0]              count_q, count_d;

  always_comb begin
    flags_d  = flags_q;
    addr_d   = addr_q;
    data_d   = data_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;

    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (kill_i && flags_q[i].valid && (addr_q[i] == kill_addr_i)) begin
        flags_d[i].killed = 1'b1;
      end
    end

    if (pop_i) begin
      flags_d[rd_ptr_q] = '0;
      rd_ptr_d          = rd_ptr_q + PtrW'(1);
    end

    // The parent never pushes while full, so push and pop slots cannot collide.
    if (push_i) begin
      flags_d[wr_ptr_q] = '{valid: 1'b1, killed: push_kill_i};
      addr_d[wr_ptr_q]  = push_addr_i;
      data_d[wr_ptr_q]  = push_data_i;
      wr_ptr_d          = wr_ptr_q + PtrW'(1);
    end

    count_d = count_q + CntW'(push_i) - CntW'(pop_i);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      flags_q  <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      flags_q  <= flags_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_comb begin
    ent_valid_o  = '0;
    ent_killed_o = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      ent_valid_o[i]  = flags_q[i].valid;
      ent_killed_o[i] = flags_q[i].killed;
    end
  end

  assign ent_addr_o = addr_q;
  assign ent_data_o = data_q;
  assign rd_ptr_o   = rd_ptr_q;
  assign count_o    = count_q;

endmodule

// File: rtl/reg_wb_queue.sv
// Register-file write port arbiter: ALU path has priority, extended-unit writes drain
// from a FIFO in idle slots, and a two-port lookup exposes pending values for forwarding.
module reg_wb_queue
  import reg_wb_queue_pkg::*;
#(
  parameter int unsigned DATA_W = DefDataW,
  parameter int unsigned ADDR_W = DefAddrW,
  parameter int unsigned DEPTH  = 4,
  localparam int unsigned PtrW  = ptr_w(DEPTH),
  localparam int unsigned CntW  = PtrW + 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_we,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              ext_valid,
  output logic              ext_ready,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_data,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] A3,
  output logic [DATA_W-1:0] WD3,
  input  logic [ADDR_W-1:0] q_addr1,
  output logic              q_hit1,
  output logic [DATA_W-1:0] q_data1,
  input  logic [ADDR_W-1:0] q_addr2,
  output logic              q_hit2,
  output logic [DATA_W-1:0] q_data2,
  output logic [CntW-1:0]   count
);

  logic                         alu_wr;
  logic                         ext_push;
  logic                         push_kill;
  logic                         pop;
  logic [CntW-1:0]              fifo_count;
  logic [PtrW-1:0]              rd_ptr;
  logic [DEPTH-1:0]             ent_valid;
  logic [DEPTH-1:0]             ent_killed;
  logic [DEPTH-1:0][ADDR_W-1:0] ent_addr;
  logic [DEPTH-1:0][DATA_W-1:0] ent_data;

  logic                         regwrite_q, regwrite_d;
  logic [ADDR_W-1:0]            a3_q, a3_d;
  logic [DATA_W-1:0]            wd3_q, wd3_d;

  assign alu_wr    = alu_we && (alu_addr != '0);
  assign ext_ready = reset && (fifo_count < CntW'(DEPTH));
  assign ext_push  = ext_valid && ext_ready && (ext_addr != '0);
  // An ALU write in the same cycle is younger than the entry being enqueued.
  assign push_kill = alu_wr && (ext_addr == alu_addr);
  assign pop       = !alu_wr && ent_valid[rd_ptr];

  wbq_fifo #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk_i        (clock),
    .rst_ni       (reset),
    .push_i       (ext_push),
    .push_kill_i  (push_kill),
    .push_addr_i  (ext_addr),
    .push_data_i  (ext_data),
    .pop_i        (pop),
    .kill_i       (alu_wr),
    .kill_addr_i  (alu_addr),
    .count_o      (fifo_count),
    .rd_ptr_o     (rd_ptr),
    .ent_valid_o  (ent_valid),
    .ent_killed_o (ent_killed),
    .ent_addr_o   (ent_addr),
    .ent_data_o   (ent_data)
  );

  always_comb begin
    regwrite_d = 1'b0;
    a3_d       = a3_q;
    wd3_d      = wd3_q;
    if (alu_wr) begin
      regwrite_d = 1'b1;
      a3_d       = alu_addr;
      wd3_d      = alu_data;
    end else if (pop && !ent_killed[rd_ptr]) begin
      regwrite_d = 1'b1;
      a3_d       = ent_addr[rd_ptr];
      wd3_d      = ent_data[rd_ptr];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      regwrite_q <= 1'b0;
      a3_q       <= '0;
      wd3_q      <= '0;
    end else begin
      regwrite_q <= regwrite_d;
      a3_q       <= a3_d;
      wd3_q      <= wd3_d;
    end
  end

  assign RegWrite = regwrite_q;
  assign A3       = a3_q;
  assign WD3      = wd3_q;
  assign count    = fifo_count;

  logic [1:0][ADDR_W-1:0] look_addr;
  logic [1:0]             look_hit;
  logic [1:0][DATA_W-1:0] look_data;
  logic [PtrW-1:0]        slot;

  assign look_addr = {q_addr2, q_addr1};

  // Walk oldest to youngest so later matches override: the youngest live entry wins,
  // and the output stage only counts when no FIFO entry matches.
  always_comb begin
    look_hit  = '0;
    look_data = '0;
    slot      = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      if (look_addr[p] != '0) begin
        if (regwrite_q && (a3_q == look_addr[p])) begin
          look_hit[p]  = 1'b1;
          look_data[p] = wd3_q;
        end
        for (int unsigned i = 0; i < DEPTH; i++) begin
          slot = rd_ptr + PtrW'(i);
          if (ent_valid[slot] && !ent_killed[slot] && (ent_addr[slot] == look_addr[p])) begin
            look_hit[p]  = 1'b1;
            look_data[p] = ent_data[slot];
          end
        end
      end
    end
  end

  assign q_hit1  = look_hit[0];
  assign q_data1 = look_data[0];
  assign q_hit2  = look_hit[1];
  assign q_data2 = look_data[1];

endmodule

// File: tb/tb_reg_wb_queue.sv
// Self-checking bench for reg_wb_queue: directed scenarios then random traffic,
// all compared against a queue-based behavioural model.
module tb_reg_wb_queue;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int D  = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          alu_we;
  logic [AW-1:0] alu_addr;
  logic [DW-1:0] alu_data;
  logic          ext_valid;
  logic          ext_ready;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_data;
  logic          RegWrite;
  logic [AW-1:0] A3;
  logic [DW-1:0] WD3;
  logic [AW-1:0] q_addr1;
  logic          q_hit1;
  logic [DW-1:0] q_data1;
  logic [AW-1:0] q_addr2;
  logic          q_hit2;
  logic [DW-1:0] q_data2;
  logic [2:0]    count;

  always #5 clock = ~clock;

  reg_wb_queue #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .DEPTH  (D)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .alu_we    (alu_we),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .ext_valid (ext_valid),
    .ext_ready (ext_ready),
    .ext_addr  (ext_addr),
    .ext_data  (ext_data),
    .RegWrite  (RegWrite),
    .A3        (A3),
    .WD3       (WD3),
    .q_addr1   (q_addr1),
    .q_hit1    (q_hit1),
    .q_data1   (q_data1),
    .q_addr2   (q_addr2),
    .q_hit2    (q_hit2),
    .q_data2   (q_data2),
    .count     (count)
  );

  // Reference model: pending ext writes in program order plus the registered write port.
  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    bit            killed;
  } ent_t;

  ent_t          mq[$];
  logic          m_rw = 1'b0;
  logic [AW-1:0] m_a3 = '0;
  logic [DW-1:0] m_wd = '0;

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Youngest live FIFO entry first, then the output stage, else no hit.
  task automatic mlook(input logic [AW-1:0] a, output logic hit, output logic [DW-1:0] d);
    hit = 1'b0;
    d   = '0;
    if (a == 0) return;
    for (int i = mq.size() - 1; i >= 0; i--) begin
      if (!mq[i].killed && mq[i].addr == a) begin
        hit = 1'b1;
        d   = mq[i].data;
        return;
      end
    end
    if (m_rw && m_a3 == a) begin
      hit = 1'b1;
      d   = m_wd;
    end
  endtask

  task automatic check_all();
    logic          h;
    logic [DW-1:0] d;
    check("ext_ready", ext_ready, reset && (mq.size() < D));
    check("count", count, mq.size());
    check("RegWrite", RegWrite, m_rw);
    check("A3", A3, m_a3);
    check("WD3", WD3, m_wd);
    mlook(q_addr1, h, d);
    check("q_hit1", q_hit1, h);
    check("q_data1", q_data1, d);
    mlook(q_addr2, h, d);
    check("q_hit2", q_hit2, h);
    check("q_data2", q_data2, d);
  endtask

  task automatic model_update();
    bit   alu_wr;
    bit   acc;
    ent_t e;
    alu_wr = alu_we && (alu_addr != 0);
    acc    = ext_valid && reset && (mq.size() < D) && (ext_addr != 0);
    if (alu_wr) begin
      foreach (mq[i]) if (mq[i].addr == alu_addr) mq[i].killed = 1'b1;
      m_rw = 1'b1;
      m_a3 = alu_addr;
      m_wd = alu_data;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_rw = !e.killed;
      if (!e.killed) begin
        m_a3 = e.addr;
        m_wd = e.data;
      end
    end else begin
      m_rw = 1'b0;
    end
    if (acc) begin
      e.addr   = ext_addr;
      e.data   = ext_data;
      e.killed = alu_wr && (ext_addr == alu_addr);
      mq.push_back(e);
    end
  endtask

  task automatic half(input logic we, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                      input logic ev, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                      input logic [AW-1:0] qa1, input logic [AW-1:0] qa2);
    alu_we    = we;
    alu_addr  = aa;
    alu_data  = ad;
    ext_valid = ev;
    ext_addr  = ea;
    ext_data  = ed;
    q_addr1   = qa1;
    q_addr2   = qa2;
    #3;
  endtask

  task automatic fin();
    check_all();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic cyc(input logic we, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                     input logic ev, input logic [AW-1:0] ea, input logic [DW-1:0] ed);
    half(we, aa, ad, ev, ea, ed, 5'd0, 5'd0);
    fin();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
  endtask

  initial begin
    alu_we = 0; alu_addr = 0; alu_data = 0;
    ext_valid = 0; ext_addr = 0; ext_data = 0;
    q_addr1 = 0; q_addr2 = 0;

    #2;
    check_all();
    check("rst_ready", ext_ready, 1'b0);
    #10 reset = 1'b1;
    @(posedge clock);
    #1;

    // ALU write latency and single-cycle pulse
    cyc(1'b1, 5'd5, 32'h1111_1111, 1'b0, 5'd0, 32'd0);
    half(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd5, 5'd0);
    check("t1_rw", RegWrite, 1'b1);
    check("t1_a3", A3, 5'd5);
    check("t1_wd3", WD3, 32'h1111_1111);
    check("t1_hit", q_hit1, 1'b1);
    fin();
    half(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("t1_rw_off", RegWrite, 1'b0);
    fin();

    // Fill while the ALU holds the port, then drain in order
    for (int i = 1; i <= 4; i++)
      cyc(1'b1, 5'd20, 32'(i * 3), 1'b1, 5'(i), 32'(9 + i));
    half(1'b1, 5'd20, 32'h5, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("t2_count_full", count, 3'd4);
    check("t2_ready_full", ext_ready, 1'b0);
    fin();
    idle(5);

    // Kill of a pending r7 by a younger ALU write
    cyc(1'b1, 5'd21, 32'h21, 1'b1, 5'd7, 32'h70);
    cyc(1'b1, 5'd7, 32'h99, 1'b0, 5'd0, 32'd0);
    half(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd7, 5'd0);
    check("t3_wd3", WD3, 32'h99);
    fin();
    half(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("t3_killed_rw", RegWrite, 1'b0);
    fin();

    // Youngest pending value wins; address 0 never hits
    cyc(1'b1, 5'd22, 32'h22, 1'b1, 5'd9, 32'h1);
    cyc(1'b1, 5'd22, 32'h23, 1'b1, 5'd9, 32'h2);
    half(1'b1, 5'd22, 32'h24, 1'b0, 5'd0, 32'd0, 5'd9, 5'd0);
    check("t4_hit1", q_hit1, 1'b1);
    check("t4_data1", q_data1, 32'h2);
    check("t4_hit2", q_hit2, 1'b0);
    check("t4_data2", q_data2, 32'h0);
    fin();
    idle(3);

    // r0 writes: ext discarded, ALU r0 leaves the slot for draining
    cyc(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h5);
    half(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("t5_count_r0", count, 3'd0);
    check("t5_rw_r0", RegWrite, 1'b0);
    fin();
    cyc(1'b1, 5'd23, 32'h23, 1'b1, 5'd3, 32'h33);
    cyc(1'b1, 5'd0, 32'hdead, 1'b0, 5'd0, 32'd0);
    half(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
    check("t5_drain_rw", RegWrite, 1'b1);
    check("t5_drain_a3", A3, 5'd3);
    fin();

    // Asynchronous reset in the middle of a drain cycle
    for (int i = 0; i < 3; i++) cyc(1'b1, 5'd24, 32'h24, 1'b1, 5'(10 + i), 32'(100 + i));
    half(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 5'd11, 5'd0);
    reset = 1'b0;
    #1;
    mq.delete();
    m_rw = 1'b0; m_a3 = '0; m_wd = '0;
    check("t6_ready", ext_ready, 1'b0);
    check("t6_count", count, 3'd0);
    check("t6_rw", RegWrite, 1'b0);
    check_all();
    @(posedge clock);
    #1;
    check_all();
    reset = 1'b1;
    idle(3);

    // Random traffic with alternating ALU pressure
    for (int i = 0; i < 400; i++) begin
      int unsigned bias;
      bias = ((i / 50) % 2 == 1) ? 8 : 3;
      half(($urandom_range(0, 9) < bias), 5'($urandom_range(0, 7)), $urandom,
           ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
           5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
      fin();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/reg_wb_queue.md
Name: reg_wb_queue

Overview:
- Write-side front end for the CPU register file. It produces the file's RegWrite/A3/WD3 write port.
- Two producers feed it:
  - the single-cycle ALU path, which has top priority and is never stalled;
  - a multi-cycle extended unit (load/mul/div), connected through a valid/ready handshake and buffered in a small FIFO.
- A two-port lookup returns pending (not-yet-written) values so decode can forward or stall.

Parameters:
DATA_W, 32, data word width
ADDR_W, 5, register address width
DEPTH, 4, extended-unit FIFO entries (power of two, ≥2)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
alu_we  in  1  ALU write request this cycle
alu_addr  in  ADDR_W  ALU destination register
alu_data  in  DATA_W  ALU result
ext_valid  in  1  extended-unit write request valid
ext_ready  out  1  FIFO can accept
ext_addr  in  ADDR_W  extended destination register
ext_data  in  DATA_W  extended result
RegWrite  out  1  register-file write enable (registered)
A3  out  ADDR_W  register-file write address (registered)
WD3  out  DATA_W  register-file write data (registered)
q_addr1  in  ADDR_W  lookup address, port 1
q_hit1  out  1  pending write to q_addr1 exists
q_data1  out  DATA_W  youngest pending value for q_addr1
q_addr2  in  ADDR_W  lookup address, port 2
q_hit2  out  1  pending write to q_addr2 exists
q_data2  out  DATA_W  youngest pending value for q_addr2
count  out  clog2(DEPTH)+1  FIFO occupancy, killed entries included

Behaviour:
- Reset asserted (low):
  - RegWrite=0, A3=0, WD3=0, count=0;
  - all entries invalid, ext_ready=0;
  - takes effect immediately and asynchronously, including mid-drain; the in-flight write is lost.
- ext_ready = reset high AND count<DEPTH. It is computed from registered count only.
- A full FIFO that is draining this cycle still reports ext_ready=0.
- Enqueue on ext_valid&&ext_ready.
  - ext_addr==0 is accepted and discarded; it is not enqueued.
- ALU write: alu_we=1 with alu_addr≠0 loads the output stage at the next edge (RegWrite=1, A3=alu_addr, WD3=alu_data). Latency is 1 cycle.
- FIFO drain:
  - The head is dequeued only in cycles with no ALU write (alu_we=0, or alu_addr=0).
  - Live head: output stage gets RegWrite=1 with the head addr/data.
  - Killed head: dequeued with RegWrite=0.
- Idle cycle (no ALU write, FIFO empty): RegWrite=0. A3/WD3 hold their previous value.
- WAW kill rule: an ALU write to X≠0 is newer in program order than every FIFO entry.
  - On that edge, all FIFO entries with addr X are marked killed.
  - An ext entry to X enqueued in the same cycle is enqueued killed.
- Simultaneous enqueue and dequeue: count is unchanged; pointers wrap modulo DEPTH.
- Lookup (combinational):
  - q_addrN==0 gives hit=0 and data=0.
  - Otherwise search live FIFO entries, youngest first.
  - If none match, use the output stage when RegWrite=1 && A3==q_addrN.
  - If still no match, hit=0 and data=0.
- The output stage counts as pending because the register file commits it only at the next edge.
- Starvation: back-to-back ALU writes may hold the FIFO indefinitely. ext_ready then deasserts; this is intended back-pressure.

Decomposition:
- Shared package/header: DATA_W/ADDR_W defaults, ZERO_WORD, the entry struct/fields (valid, killed, addr, data), and the pointer-width helper.
- One sub-module is natural: wbq_fifo, the circular buffer with pointers, count, and the per-entry killed vector, exposing its entries for the kill compare and the lookup.
- The priority mux and lookup stay in reg_wb_queue.

Test Plan:
- Release reset; ALU writes r5=0x11111111 at cycle n → RegWrite=1, A3=5, WD3=0x11111111 at n+1; RegWrite=0 at n+2.
- Enqueue ext writes r1=0xA, r2=0xB, r3=0xC, r4=0xD while alu_we=1 every cycle → count=4, ext_ready=0; drop alu_we → four writes in order over 4 cycles; ext_ready=1 once count=3.
- Enqueue ext r7=0x70, then ALU writes r7=0x99 → the r7 entry is killed; the drain slot shows RegWrite=0; no write of 0x70 occurs after 0x99.
- Enqueue ext r9=0x1, then r9=0x2; set q_addr1=9 → q_hit1=1, q_data1=0x2. q_addr2=0 → q_hit2=0, q_data2=0.
- ext write to r0 → not enqueued, count unchanged, no RegWrite; ALU write to r0 → FIFO drains that cycle.
- Drop reset mid-drain with count=3 → outputs zero immediately, ext_ready=0; after release count=0 and no stale writes appear.
